// File: rtl/alu_pkg.sv
// Shared constants for the ALU and the command engine that drives it:
// opcode encodings, flag bit positions and counter widths.
package alu_pkg;

  localparam int OPCODE_W = 4;
  localparam int NUM_FLAGS = 5;

  // Opcode encodings; 0 and 10-15 are invalid.
  localparam logic [OPCODE_W-1:0] OP_ADD       = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD_CARRY = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_SUB       = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_INC       = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_DEC       = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_AND       = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_NOT       = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_ROL       = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_ROR       = 4'd9;

  // Flag vector layout: {invalid_op, parity, zero, borrow, carry_out}.
  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_BORROW  = 1;
  localparam int FLAG_ZERO    = 2;
  localparam int FLAG_PARITY  = 3;
  localparam int FLAG_INVALID = 4;

  localparam int OP_CNT_W  = 16;
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage : alu_pkg

// File: rtl/alu.sv
// Purely combinational ALU. Parity flag is 1 when the result holds an even
// number of ones. For SUB and DEC the carry_out reports the borrow, so the
// stored carry in the engine always reflects the last wrap-around.
module alu
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [OPCODE_W-1:0]  op,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BUS_WIDTH-1:0] y,
  output logic [NUM_FLAGS-1:0] flags
);

  localparam logic [BUS_WIDTH:0]   ONE_EXT = {{BUS_WIDTH{1'b0}}, 1'b1};
  localparam logic [BUS_WIDTH-1:0] ONE     = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  logic [BUS_WIDTH:0]   sum;
  logic [BUS_WIDTH-1:0] y_int;
  logic                 carry;
  logic                 borrow;
  logic                 invalid;

  // Opcode decode and arithmetic; flags derived from the result afterwards.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value unassigned and infers a latch.
    sum     = '0;
    y_int   = '0;
    carry   = 1'b0;
    borrow  = 1'b0;
    invalid = 1'b0;
    unique case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        y_int = sum[BUS_WIDTH-1:0];
        carry = sum[BUS_WIDTH];
      end
      OP_ADD_CARRY: begin
        sum   = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_in};
        y_int = sum[BUS_WIDTH-1:0];
        carry = sum[BUS_WIDTH];
      end
      OP_SUB: begin
        y_int  = a - b;
        borrow = (a < b);
        carry  = borrow;
      end
      OP_INC: begin
        sum   = {1'b0, a} + ONE_EXT;
        y_int = sum[BUS_WIDTH-1:0];
        carry = sum[BUS_WIDTH];
      end
      OP_DEC: begin
        y_int  = a - ONE;
        borrow = (a == '0);
        carry  = borrow;
      end
      OP_AND: y_int = a & b;
      OP_NOT: y_int = ~a;
      OP_ROL: begin
        y_int = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
        carry = a[BUS_WIDTH-1];
      end
      OP_ROR: begin
        y_int = {a[0], a[BUS_WIDTH-1:1]};
        carry = a[0];
      end
      default: invalid = 1'b1;
    endcase
  end

  assign y = y_int;

  always_comb begin
    flags               = '0;
    flags[FLAG_CARRY]   = carry;
    flags[FLAG_BORROW]  = borrow;
    flags[FLAG_ZERO]    = (y_int == '0);
    flags[FLAG_PARITY]  = ~(^y_int);
    flags[FLAG_INVALID] = invalid;
  end

endmodule : alu

// File: rtl/alu_cmd_engine.sv
// Command engine around the combinational ALU. One command at a time:
// accept in IDLE, evaluate in EXEC, hold the result in RESP until taken.
// Keeps a stored carry for chained multi-word arithmetic plus op/error counts.
module alu_cmd_engine
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OPCODE_W-1:0]  req_opcode,
  input  logic [BUS_WIDTH-1:0] req_a,
  input  logic [BUS_WIDTH-1:0] req_b,
  input  logic                 req_chain,
  input  logic                 req_carry_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_y,
  output logic [NUM_FLAGS-1:0] rsp_flags,
  output logic [OP_CNT_W-1:0]  op_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [OPCODE_W-1:0]  op_q, op_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic                 cin_q, cin_d;
  logic [BUS_WIDTH-1:0] y_q, y_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 carry_q, carry_d;
  logic [OP_CNT_W-1:0]  op_count_q, op_count_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [BUS_WIDTH-1:0] alu_y;
  logic [NUM_FLAGS-1:0] alu_flags;

  alu #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .carry_in (cin_q),
    .y        (alu_y),
    .flags    (alu_flags)
  );

  // Next-state logic: accept in IDLE, capture in EXEC, release in RESP.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    y_d         = y_q;
    flags_d     = flags_q;
    carry_d     = carry_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_opcode;
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_chain ? carry_q : req_carry_in;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        y_d     = alu_y;
        flags_d = alu_flags;
        if (alu_flags[FLAG_INVALID]) begin
          // Invalid ops leave the stored carry alone and saturate the count.
          if (err_count_q != ERR_CNT_MAX) err_count_d = err_count_q + 1'b1;
        end else begin
          carry_d    = alu_flags[FLAG_CARRY];
          op_count_d = op_count_q + 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the operand registers are reset too, so the ALU never sees X
    // after reset and the outputs are fully defined from the first cycle.
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
      carry_q     <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // pre-edge values no matter how the statements are ordered.
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      carry_q     <= carry_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_y     = y_q;
  assign rsp_flags = flags_q;
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule : alu_cmd_engine

// File: doc/alu_cmd_engine.md
ALU_CMD_ENGINE -- requirements
Module: alu_cmd_engine

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, giving operand and result width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have req_valid  input  1  command present.
REQ-005 SHALL have req_ready  output  1  engine accepts a command this cycle.
REQ-006 SHALL have req_opcode  input  4  ALU opcode: 1 ADD, 2 ADD_CARRY, 3 SUB, 4 INC, 5 DEC, 6 AND, 7 NOT, 8 ROL, 9 ROR; 0 and 10-15 invalid.
REQ-007 SHALL have req_a, req_b  input  BUS_WIDTH  operands.
REQ-008 SHALL have req_chain  input  1  1 = carry_in comes from the stored carry; 0 = from req_carry_in.
REQ-009 SHALL have req_carry_in  input  1  explicit carry_in.
REQ-010 SHALL have rsp_valid  output  1  result available.
REQ-011 SHALL have rsp_ready  input  1  consumer takes the result.
REQ-012 SHALL have rsp_y  output  BUS_WIDTH  registered ALU result.
REQ-013 SHALL have rsp_flags  output  5  registered {invalid_op, parity, zero, borrow, carry_out}.
REQ-014 SHALL have op_count  output  16  completed valid operations, wrapping.
REQ-015 SHALL have err_count  output  8  completed invalid operations, saturating at 255.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 A handshake (req_valid & req_ready) at edge N SHALL register opcode, operands and the selected carry_in, then enter EXEC.
REQ-019 In EXEC, the registered inputs SHALL drive the alu instance; at edge N+1 y and flags are captured into rsp_y/rsp_flags and the FSM enters RESP.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, i.e. from after edge N+1 on; latency is 2 edges from accept to visible result.
REQ-021 rsp_y and rsp_flags SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-022 On rsp_valid & rsp_ready at an edge, the FSM SHALL return to IDLE; a new command can be accepted no earlier than the following edge (throughput 1 op per 3 cycles minimum).
REQ-023 The stored carry SHALL update at the capture edge to carry_out of every valid op and be unchanged by invalid ops.
REQ-024 An invalid opcode SHALL still complete the full handshake, with rsp_flags[4]=1 and rsp_y as produced by the ALU.
REQ-025 At the capture edge, op_count SHALL increment for valid ops (FFFF wraps to 0) and err_count SHALL increment for invalid ops (holds at 255).
REQ-026 req_valid in EXEC or RESP SHALL be ignored (no accept, no state change).

Reset
REQ-027 While reset_n=0: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_y=0, rsp_flags=0, stored carry=0, op_count=0, err_count=0.
REQ-028 Reset asserted in EXEC or RESP SHALL abort the op with no result and no counter update.

Structure
REQ-029 The opcode constants (OP_ADD..OP_ROR) and the flag bit positions SHALL live in a shared package, alu_pkg.
REQ-030 SHALL instantiate the existing combinational alu as its one sub-module, passing BUS_WIDTH through.

Verification
REQ-031 ADD: a=9, b=33, chain=0, carry_in=0 -> rsp_y=42, flags=00000, op_count=1.
REQ-032 Chained multi-byte add: ADD a=200, b=100 -> y=44, carry=1; then ADD_CARRY chain=1, a=1, b=1 -> y=3.
REQ-033 SUB: a=65, b=66 -> y=255, borrow=1; stored carry stays at its earlier value or its defined update.
REQ-034 Opcode 12 -> invalid_op=1, err_count increments, op_count and stored carry unchanged; 256 invalid ops -> err_count=255.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid stays high, rsp_y stable, req_ready=0, second req_valid not accepted.
REQ-036 Reset pulsed in EXEC -> rsp_valid never rises, counters 0, req_ready=1 after release.
